// File: rtl/servo_motion_sequencer.sv
// -----------------------------------------------------------------------------
// servo_motion_sequencer
//
// Purpose:
//   Produces the 8-bit duty_cycle value consumed by the servo PWM generator.
//   Position commands arrive over a valid/ready handshake.  duty_cycle slews
//   toward the commanded target by STEP counts once per update tick.  There is
//   also an autonomous triangle sweep between MIN_POS and MAX_POS, and a freeze
//   mode that holds the current position.
//
// Parameters:
//   TICK_CYCLES  clk cycles per position update (>= 1)
//   STEP         duty counts moved per tick (1..255)
//   MIN_POS      sweep lower bound / soft-limit floor
//   MAX_POS      sweep upper bound / soft-limit ceiling (MIN_POS < MAX_POS)
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous reset, active-high
//   mode    [1:0] in   00 manual, 01 sweep, 1x freeze
//   target  [7:0] in   commanded position
//   target_valid  in   target presented
//   target_ready  out  a target can be accepted this cycle (IDLE/MOVE)
//   duty_cycle[7:0] out position driven to the PWM generator
//   busy          out  moving toward target, or sweeping
//   at_target     out  one-cycle pulse when manual motion reaches its target
//
// Configuration macro:
//   SERVO_SOFT_LIMIT_EN  when defined, accepted targets are clamped into
//                        [MIN_POS, MAX_POS] as they are latched.  When not
//                        defined, targets are latched unmodified and the
//                        bounds only constrain the sweep.
// -----------------------------------------------------------------------------
module servo_motion_sequencer #(
  parameter int TICK_CYCLES = 20000,
  parameter int STEP        = 4,
  parameter int MIN_POS     = 0,
  parameter int MAX_POS     = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [7:0] target,
  input  logic       target_valid,
  output logic       target_ready,
  output logic [7:0] duty_cycle,
  output logic       busy,
  output logic       at_target
);

  localparam int               CNT_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [7:0]       MIN_P    = 8'(MIN_POS);
  localparam logic [7:0]       MAX_P    = 8'(MAX_POS);
  localparam logic [7:0]       STEP_P   = 8'(STEP);
  localparam logic [9:0]       STEP_W   = 10'(STEP);
  localparam logic [9:0]       MAX_W    = 10'(MAX_POS);
  // duty - STEP would land at or below MIN_POS once duty <= MIN_POS + STEP
  localparam logic [9:0]       DN_FLOOR = 10'(MIN_POS + STEP);

  typedef enum logic [2:0] {
    IDLE,
    MOVE,
    SWEEP_UP,
    SWEEP_DN,
    FREEZE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [7:0]       target_reg;
  logic [7:0]       target_next;
  logic [7:0]       target_eff;
  logic [7:0]       duty_next;
  logic             at_next;
  logic             accept;

  logic signed [8:0] diff;
  logic [8:0]        mag;
  logic              move_done;
  logic [7:0]        move_val;
  logic [9:0]        up_sum;
  logic [7:0]        up_val;
  logic [7:0]        dn_val;

  // ---------------------------------------------------------------------------
  // Update tick: free-running, unaffected by mode or state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick_cnt == CNT_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Target conditioning
  // ---------------------------------------------------------------------------
`ifdef SERVO_SOFT_LIMIT_EN
  always_comb begin
    target_eff = target;
    if (int'(target) < MIN_POS) begin
      target_eff = MIN_P;
    end else if (int'(target) > MAX_POS) begin
      target_eff = MAX_P;
    end
  end
`else
  assign target_eff = target;
`endif

  // The handshake is honoured whenever ready is high, even if a mode change
  // wins the state transition on the same cycle; the target is then used
  // when manual mode resumes.
  assign accept = target_valid & target_ready;

  // ---------------------------------------------------------------------------
  // Step arithmetic
  // ---------------------------------------------------------------------------
  // Manual slew: a 9-bit signed distance covers -255..+255.  When the distance
  // exceeds STEP, stepping toward the target can never cross 0 or 255.
  assign diff      = $signed({1'b0, target_reg}) - $signed({1'b0, duty_cycle});
  assign mag       = diff[8] ? 9'(-diff) : 9'(diff);
  assign move_done = (mag <= {1'b0, STEP_P});
  assign move_val  = move_done ? target_reg
                   : (diff[8] ? duty_cycle - STEP_P : duty_cycle + STEP_P);

  // Sweep: saturate at the bounds (10-bit sum avoids 8-bit wrap).
  assign up_sum = {2'b00, duty_cycle} + STEP_W;
  assign up_val = (up_sum >= MAX_W) ? MAX_P : up_sum[7:0];
  assign dn_val = ({2'b00, duty_cycle} <= DN_FLOOR) ? MIN_P : duty_cycle - STEP_P;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic.  Priority: mode change, accept, tick step.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    duty_next   = duty_cycle;
    target_next = target_reg;
    at_next     = 1'b0;

    if (accept) begin
      target_next = target_eff;
    end

    if (mode[1]) begin
      // Freeze: hold duty, ignore ticks.
      state_next = FREEZE;
    end else if (mode[0]) begin
      case (state)
        SWEEP_UP: begin
          if (tick) begin
            duty_next = up_val;
            if (up_val == MAX_P) begin
              state_next = SWEEP_DN;
            end
          end
        end
        SWEEP_DN: begin
          if (tick) begin
            duty_next = dn_val;
            if (dn_val == MIN_P) begin
              state_next = SWEEP_UP;
            end
          end
        end
        default: begin
          // Entering sweep; the entry cycle itself does not step.
          state_next = (duty_cycle < MAX_P) ? SWEEP_UP : SWEEP_DN;
        end
      endcase
    end else begin
      case (state)
        SWEEP_UP, SWEEP_DN, FREEZE: begin
          // Resume manual motion toward whatever target was last latched.
          state_next = (duty_cycle == target_reg) ? IDLE : MOVE;
        end
        default: begin
          if (accept) begin
            // A fresh target suppresses any step on this cycle.
            if (target_eff == duty_cycle) begin
              state_next = IDLE;
              at_next    = 1'b1;
            end else begin
              state_next = MOVE;
            end
          end else if ((state == MOVE) && tick) begin
            duty_next = move_val;
            if (move_done) begin
              state_next = IDLE;
              at_next    = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  // target_ready is registered from the next state, so it reads 0 on the first
  // cycle after reset release and rises with the first clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      duty_cycle   <= MIN_P;
      target_reg   <= MIN_P;
      target_ready <= 1'b0;
      busy         <= 1'b0;
      at_target    <= 1'b0;
    end else begin
      state        <= state_next;
      duty_cycle   <= duty_next;
      target_reg   <= target_next;
      target_ready <= (state_next == IDLE) || (state_next == MOVE);
      busy         <= (state_next != IDLE) && (state_next != FREEZE);
      at_target    <= at_next;
    end
  end

endmodule

// File: tb/tb_servo_motion_sequencer.sv
// -----------------------------------------------------------------------------
// tb_servo_motion_sequencer
//
// Two sequencers share one stimulus stream: dut_a spans the full 0..255 range,
// dut_b is bounded to 10..30.  A behavioural model tracks, per instance, the
// operating mode last applied, the latched target, the position and the sweep
// direction, and predicts duty/busy/at_target/target_ready every cycle.
// Define SERVO_SOFT_LIMIT_EN for both RTL and bench to exercise soft limits.
// -----------------------------------------------------------------------------
module tb_servo_motion_sequencer;

  localparam int TC   = 4;
  localparam int ST   = 4;
  localparam int A_LO = 0;
  localparam int A_HI = 255;
  localparam int B_LO = 10;
  localparam int B_HI = 30;
`ifdef SERVO_SOFT_LIMIT_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  logic       clk          = 1'b0;
  logic       rst          = 1'b0;
  logic [1:0] mode         = 2'b00;
  logic [7:0] target       = 8'd0;
  logic       target_valid = 1'b0;
  logic       ready_a, busy_a, at_a;
  logic       ready_b, busy_b, at_b;
  logic [7:0] duty_a, duty_b;

  always #5 clk = ~clk;

  servo_motion_sequencer #(
    .TICK_CYCLES(TC), .STEP(ST), .MIN_POS(A_LO), .MAX_POS(A_HI)
  ) dut_a (
    .clk(clk), .rst(rst), .mode(mode), .target(target), .target_valid(target_valid),
    .target_ready(ready_a), .duty_cycle(duty_a), .busy(busy_a), .at_target(at_a)
  );

  servo_motion_sequencer #(
    .TICK_CYCLES(TC), .STEP(ST), .MIN_POS(B_LO), .MAX_POS(B_HI)
  ) dut_b (
    .clk(clk), .rst(rst), .mode(mode), .target(target), .target_valid(target_valid),
    .target_ready(ready_b), .duty_cycle(duty_b), .busy(busy_b), .at_target(at_b)
  );

  // em: 0 manual, 1 sweep, 2 freeze (mode applied at the last edge)
  typedef struct packed {
    int duty;
    int tgt;
    int em;
    bit up;
    bit live;
    bit pulse;
    bit busy;
  } mdl_t;

  mdl_t ma, mb;
  int   tcnt;
  int   checks = 0;
  int   passed = 0;

  function automatic int lim(int t, int lo, int hi);
    if (SOFT && t < lo) return lo;
    if (SOFT && t > hi) return hi;
    return t;
  endfunction

  function automatic mdl_t mdl_reset(int lo);
    mdl_t m;
    m.duty = lo; m.tgt = lo; m.em = 0; m.up = 1'b1;
    m.live = 1'b0; m.pulse = 1'b0; m.busy = 1'b0;
    return m;
  endfunction

  function automatic mdl_t model_next(mdl_t s, logic [1:0] md, int t, bit v,
                                      int lo, int hi, bit tick);
    mdl_t n = s;
    int   nm;
    int   d;
    n.pulse = 1'b0;
    n.live  = 1'b1;
    nm = md[1] ? 2 : (md[0] ? 1 : 0);
    // Ready is offered only in manual operation once out of reset.
    if (v && s.live && s.em == 0) n.tgt = lim(t, lo, hi);
    if (nm != s.em) begin
      if (nm == 1) n.up = (s.duty < hi);
    end else if (nm == 0) begin
      if (v && s.live) begin
        if (n.tgt == s.duty) n.pulse = 1'b1;
      end else if (tick && s.duty != s.tgt) begin
        d = s.tgt - s.duty;
        if (d > ST) n.duty = s.duty + ST;
        else if (d < -ST) n.duty = s.duty - ST;
        else begin n.duty = s.tgt; n.pulse = 1'b1; end
      end
    end else if (nm == 1 && tick) begin
      if (s.up) begin
        n.duty = (s.duty + ST > hi) ? hi : s.duty + ST;
        if (n.duty == hi) n.up = 1'b0;
      end else begin
        n.duty = (s.duty - ST < lo) ? lo : s.duty - ST;
        if (n.duty == lo) n.up = 1'b1;
      end
    end
    n.em   = nm;
    n.busy = (nm == 1) || (nm == 0 && n.duty != n.tgt);
    return n;
  endfunction

  // {duty, busy, at_target, target_ready} predicted by the model
  function automatic logic [10:0] exp_of(mdl_t m);
    return {m.duty[7:0], m.busy, m.pulse, (m.live && m.em == 0)};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma   <= mdl_reset(A_LO);
      mb   <= mdl_reset(B_LO);
      tcnt <= 0;
    end else begin
      ma   <= model_next(ma, mode, int'(target), target_valid, A_LO, A_HI, tcnt == TC-1);
      mb   <= model_next(mb, mode, int'(target), target_valid, B_LO, B_HI, tcnt == TC-1);
      tcnt <= (tcnt == TC-1) ? 0 : tcnt + 1;
    end
  end

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (duty_a !== 8'd0) $display("FAIL reset_duty_a got %0d expected 0", duty_a); else passed++;
    checks++; if (duty_b !== 8'd10) $display("FAIL reset_duty_b got %0d expected 10", duty_b); else passed++;
    checks++; if ({busy_a, at_a, ready_a} !== 3'b000) $display("FAIL reset_flags_a got %b expected 000", {busy_a, at_a, ready_a}); else passed++;
    checks++; if ({busy_b, at_b, ready_b} !== 3'b000) $display("FAIL reset_flags_b got %b expected 000", {busy_b, at_b, ready_b}); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({duty_a, busy_a, at_a, ready_a} !== {8'd0, 3'b001}) $display("FAIL reset_release_a got %h expected %h", {duty_a, busy_a, at_a, ready_a}, {8'd0, 3'b001}); else passed++;
    $display("reset: duty_a=%0d duty_b=%0d ready=%b", duty_a, duty_b, ready_a);
  endtask

  task automatic test_manual();
    int pulses = 0;
    mode = 2'b00; target = 8'd20; target_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      target_valid = 1'b0;
      checks++; if ({duty_a, busy_a, at_a, ready_a} !== exp_of(ma)) $display("FAIL manual_a got %h expected %h", {duty_a, busy_a, at_a, ready_a}, exp_of(ma)); else passed++;
      checks++; if ({duty_b, busy_b, at_b, ready_b} !== exp_of(mb)) $display("FAIL manual_b got %h expected %h", {duty_b, busy_b, at_b, ready_b}, exp_of(mb)); else passed++;
      if (at_a) pulses++;
    end
    checks++; if (duty_a !== 8'd20) $display("FAIL manual_settle got %0d expected 20", duty_a); else passed++;
    checks++; if (pulses != 1) $display("FAIL manual_pulses got %0d expected 1", pulses); else passed++;
    $display("manual: target=20 duty_a=%0d pulses=%0d busy=%b", duty_a, pulses, busy_a);
    pulses = 0;
    target = 8'd22; target_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      target_valid = 1'b0;
      checks++; if ({duty_a, busy_a, at_a, ready_a} !== exp_of(ma)) $display("FAIL small_step_a got %h expected %h", {duty_a, busy_a, at_a, ready_a}, exp_of(ma)); else passed++;
      if (at_a) pulses++;
    end
    checks++; if (duty_a !== 8'd22 || pulses != 1) $display("FAIL small_step_settle got %0d/%0d expected 22/1", duty_a, pulses); else passed++;
    $display("manual: target=22 duty_a=%0d pulses=%0d", duty_a, pulses);
  endtask

  task automatic test_retarget();
    int lowest = 255;
    bit hit = 1'b0;
    target = 8'd200; target_valid = 1'b1;
    for (int i = 0; i < 150 && !hit; i++) begin
      @(negedge clk);
      target_valid = 1'b0;
      checks++; if ({duty_a, busy_a, at_a, ready_a} !== exp_of(ma)) $display("FAIL retarget_up_a got %h expected %h", {duty_a, busy_a, at_a, ready_a}, exp_of(ma)); else passed++;
      if (duty_a >= 8'd40) hit = 1'b1;
    end
    checks++; if (!hit) $display("FAIL retarget_reach40 got %0d expected >=40", duty_a); else passed++;
    target = 8'd10; target_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      target_valid = 1'b0;
      checks++; if ({duty_a, busy_a, at_a, ready_a} !== exp_of(ma)) $display("FAIL retarget_dn_a got %h expected %h", {duty_a, busy_a, at_a, ready_a}, exp_of(ma)); else passed++;
      checks++; if ({duty_b, busy_b, at_b, ready_b} !== exp_of(mb)) $display("FAIL retarget_dn_b got %h expected %h", {duty_b, busy_b, at_b, ready_b}, exp_of(mb)); else passed++;
      if (int'(duty_a) < lowest) lowest = int'(duty_a);
    end
    checks++; if (duty_a !== 8'd10 || lowest != 10) $display("FAIL retarget_settle got %0d min %0d expected 10", duty_a, lowest); else passed++;
    $display("retarget: 200 then 10, duty_a=%0d lowest=%0d", duty_a, lowest);
  endtask

  task automatic test_sweep_freeze();
    int bmin = 255;
    int bmax = 0;
    mode = 2'b01;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      target = 8'($urandom_range(0, 255));
      target_valid = 1'($urandom_range(0, 1));
      checks++; if ({duty_a, busy_a, at_a, ready_a} !== exp_of(ma)) $display("FAIL sweep_a got %h expected %h", {duty_a, busy_a, at_a, ready_a}, exp_of(ma)); else passed++;
      checks++; if ({duty_b, busy_b, at_b, ready_b} !== exp_of(mb)) $display("FAIL sweep_b got %h expected %h", {duty_b, busy_b, at_b, ready_b}, exp_of(mb)); else passed++;
      if (int'(duty_b) < bmin) bmin = int'(duty_b);
      if (int'(duty_b) > bmax) bmax = int'(duty_b);
    end
    checks++; if (bmin != B_LO || bmax != B_HI) $display("FAIL sweep_bounds got %0d..%0d expected %0d..%0d", bmin, bmax, B_LO, B_HI); else passed++;
    $display("sweep: dut_b range %0d..%0d", bmin, bmax);
    target_valid = 1'b0;
    mode = 2'b10;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if ({duty_b, busy_b, at_b, ready_b} !== exp_of(mb)) $display("FAIL freeze_b got %h expected %h", {duty_b, busy_b, at_b, ready_b}, exp_of(mb)); else passed++;
      checks++; if ({duty_a, busy_a, at_a, ready_a} !== exp_of(ma)) $display("FAIL freeze_a got %h expected %h", {duty_a, busy_a, at_a, ready_a}, exp_of(ma)); else passed++;
    end
    $display("freeze: duty_a=%0d duty_b=%0d busy=%b", duty_a, duty_b, busy_b);
    mode = 2'b00;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++; if ({duty_a, busy_a, at_a, ready_a} !== exp_of(ma)) $display("FAIL resume_a got %h expected %h", {duty_a, busy_a, at_a, ready_a}, exp_of(ma)); else passed++;
      checks++; if ({duty_b, busy_b, at_b, ready_b} !== exp_of(mb)) $display("FAIL resume_b got %h expected %h", {duty_b, busy_b, at_b, ready_b}, exp_of(mb)); else passed++;
    end
    $display("resume manual: duty_a=%0d duty_b=%0d", duty_a, duty_b);
  endtask

  task automatic test_soft_limit();
    mode = 2'b00; target = 8'd250; target_valid = 1'b1;
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      target_valid = 1'b0;
      checks++; if ({duty_b, busy_b, at_b, ready_b} !== exp_of(mb)) $display("FAIL limit_b got %h expected %h", {duty_b, busy_b, at_b, ready_b}, exp_of(mb)); else passed++;
    end
    checks++; if (duty_a !== 8'd250) $display("FAIL limit_a_settle got %0d expected 250", duty_a); else passed++;
    checks++; if (duty_b !== (SOFT ? 8'd30 : 8'd250)) $display("FAIL limit_b_settle got %0d expected %0d", duty_b, SOFT ? 30 : 250); else passed++;
    $display("limit: target=250 duty_a=%0d duty_b=%0d", duty_a, duty_b);
    target = 8'd252; target_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      target_valid = 1'b0;
    end
    target = 8'd255; target_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      target_valid = 1'b0;
      checks++; if ({duty_a, busy_a, at_a, ready_a} !== exp_of(ma)) $display("FAIL top_edge_a got %h expected %h", {duty_a, busy_a, at_a, ready_a}, exp_of(ma)); else passed++;
    end
    checks++; if (duty_a !== 8'd255) $display("FAIL top_edge_settle got %0d expected 255", duty_a); else passed++;
    $display("limit: target=255 duty_a=%0d duty_b=%0d", duty_a, duty_b);
  endtask

  task automatic test_back_to_back();
    int hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 9))
          7, 8:    mode = 2'b01;
          9:       mode = 2'($urandom_range(2, 3));
          default: mode = 2'b00;
        endcase
        hold = $urandom_range(1, 40);
      end
      hold--;
      target_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 5))
        0:       target = 8'd0;
        1:       target = 8'd255;
        default: target = 8'($urandom_range(0, 255));
      endcase
      @(negedge clk);
      checks++; if ({duty_a, busy_a, at_a, ready_a} !== exp_of(ma)) $display("FAIL random_a cyc %0d got %h expected %h", i, {duty_a, busy_a, at_a, ready_a}, exp_of(ma)); else passed++;
      checks++; if ({duty_b, busy_b, at_b, ready_b} !== exp_of(mb)) $display("FAIL random_b cyc %0d got %h expected %h", i, {duty_b, busy_b, at_b, ready_b}, exp_of(mb)); else passed++;
    end
    target_valid = 1'b0;
    $display("random: 800 cycles, duty_a=%0d duty_b=%0d", duty_a, duty_b);
  endtask

  task automatic test_async_reset();
    mode = 2'b00; target = 8'd0; target_valid = 1'b1;
    @(negedge clk);
    target_valid = 1'b0;
    mode = 2'b00; target = (duty_a > 8'd128) ? 8'd0 : 8'd255; target_valid = 1'b1;
    repeat (10) @(negedge clk) target_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if (duty_a !== 8'd0 || duty_b !== 8'd10) $display("FAIL async_duty got %0d/%0d expected 0/10", duty_a, duty_b); else passed++;
    checks++; if ({busy_a, at_a, ready_a, busy_b} !== 4'b0000) $display("FAIL async_flags got %b expected 0000", {busy_a, at_a, ready_a, busy_b}); else passed++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if ({duty_a, busy_a, at_a, ready_a} !== exp_of(ma)) $display("FAIL post_reset_a got %h expected %h", {duty_a, busy_a, at_a, ready_a}, exp_of(ma)); else passed++;
    end
    checks++; if (duty_a !== 8'd0 || busy_a !== 1'b0) $display("FAIL post_reset_idle got %0d/%b expected 0/0", duty_a, busy_a); else passed++;
    $display("async reset: duty_a=%0d duty_b=%0d busy=%b", duty_a, duty_b, busy_a);
  endtask

  initial begin
    test_reset();
    test_manual();
    test_retarget();
    test_sweep_freeze();
    test_soft_limit();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
